// File: rtl/interpolate_x8_if.sv
// Sample-in / tick-out bundle for the 1:8 interpolating upsampler.
interface interpolate_x8_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               out_tick;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               underrun;

  modport master (
    output in_valid, in_data, out_tick,
    input  in_ready, out_valid, out_data, underrun
  );

  modport slave (
    input  in_valid, in_data, out_tick,
    output in_ready, out_valid, out_data, underrun
  );
endinterface

// File: rtl/interpolate_x8.sv
// Linear 1:8 upsampler: one interpolated point per out_tick, registered (tick at T -> data at T+1).
// Backpressure: one-entry pending buffer, in_ready = !pend_valid; ramps to silence on underrun.
module interpolate_x8 (
  input  logic             clock,
  input  logic             reset,
  interpolate_x8_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic signed [15:0] prev;
  logic signed [15:0] curr;
  logic signed [15:0] pend;
  logic               pend_valid;
  logic [2:0]         phase;

  logic signed [16:0] prev_w;
  logic signed [16:0] curr_w;
  logic signed [16:0] diff;
  logic signed [19:0] diff_x;
  logic signed [19:0] phase_x;
  logic signed [19:0] prod;
  logic signed [19:0] step;
  logic signed [19:0] prev_x;
  logic signed [15:0] y;

  // y stays between prev and curr, so the 16-bit truncation below never wraps.
  always_comb begin
    prev_w  = {prev[15], prev};
    curr_w  = {curr[15], curr};
    diff    = curr_w - prev_w;
    diff_x  = {{3{diff[16]}}, diff};
    phase_x = {17'd0, phase};
    prod    = diff_x * phase_x;
    step    = prod >>> 3;
    prev_x  = {{4{prev[15]}}, prev};
    y       = 16'(prev_x + step);
  end

  assign bus.in_ready = !pend_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      prev          <= '0;
      curr          <= '0;
      pend          <= '0;
      pend_valid    <= 1'b0;
      phase         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.underrun  <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.underrun  <= 1'b0;

      // Accept and consume are exclusive: accept needs pend empty, consume needs it full.
      if (bus.in_valid && !pend_valid) begin
        pend       <= bus.in_data;
        pend_valid <= 1'b1;
      end

      if (bus.out_tick) begin
        bus.out_valid <= 1'b1;
        case (state)
          IDLE: begin
            bus.out_data <= '0;
            if (pend_valid) begin
              prev       <= '0;
              curr       <= pend;
              pend_valid <= 1'b0;
              phase      <= '0;
              state      <= RUN;
            end
          end
          RUN: begin
            bus.out_data <= y;
            if (phase != 3'd7) begin
              phase <= phase + 3'd1;
            end else begin
              phase <= '0;
              prev  <= curr;
              if (pend_valid) begin
                curr       <= pend;
                pend_valid <= 1'b0;
              end else begin
                bus.underrun <= 1'b1;
                if (curr != 16'sd0) curr  <= '0;
                else                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
